// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches words from instruction memory into a 2-entry
// prefetch queue and presents them to decode with a valid/ready handshake.
module fetch_unit #(
    parameter int unsigned         ADDR_W   = 16,
    parameter int unsigned         DATA_W   = 16,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic              IMemReq,
    output logic [ADDR_W-1:0] IMemAddr,
    input  logic              IMemAck,
    input  logic [DATA_W-1:0] IMemData,
    output logic              InstrValid,
    input  logic              InstrReady,
    output logic [DATA_W-1:0] Instr,
    output logic [ADDR_W-1:0] InstrPC,
    output logic [2:0]        Opcode,
    input  logic              Redirect,
    input  logic [ADDR_W-1:0] RedirectPC
);

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [1:0]          count_q, count_d;
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]   instr_q [2];
    logic [ADDR_W-1:0]   ipc_q   [2];

    logic push;
    logic pop;

    assign IMemReq    = !Reset && (state_q == RUN) && (count_q < 2'd2) && !Redirect;
    assign IMemAddr   = fetch_pc_q;
    assign push       = IMemReq && IMemAck;
    assign InstrValid = (count_q != 2'd0);
    assign pop        = InstrValid && InstrReady;
    assign Instr      = instr_q[rd_ptr_q];
    assign InstrPC    = ipc_q[rd_ptr_q];
    assign Opcode     = Instr[DATA_W-1 -: 3];

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        // A redirect discards the queue even if decode pops this cycle.
        if (Redirect) begin
            state_d    = FLUSH;
            fetch_pc_d = RedirectPC;
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
        end else begin
            state_d = RUN;
            if (push) begin
                wr_ptr_d   = ~wr_ptr_q;
                fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage needs no reset: push is already gated off by Reset and Redirect.
    always_ff @(posedge Clock) begin
        if (push) begin
            instr_q[wr_ptr_q] <= IMemData;
            ipc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: two instances (reset PC 0 and 0xFFFE) share stimulus and
// are checked every cycle against a queue-level reference model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        ack;
    logic        ready;
    logic        redir;
    logic [15:0] rpc;

    logic        req0, req1, val0, val1;
    logic [15:0] addr0, addr1, data0, data1;
    logic [15:0] ins0, ins1, ipc0, ipc1;
    logic [2:0]  op0, op1;

    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'hFFFF) return 16'hE123;
        return a ^ 16'h3C5A;
    endfunction

    assign data0 = mem_word(addr0);
    assign data1 = mem_word(addr1);

    fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
        .Clock(clk), .Reset(rst), .IMemReq(req0), .IMemAddr(addr0), .IMemAck(ack),
        .IMemData(data0), .InstrValid(val0), .InstrReady(ready), .Instr(ins0),
        .InstrPC(ipc0), .Opcode(op0), .Redirect(redir), .RedirectPC(rpc)
    );

    fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFE)) dut_w (
        .Clock(clk), .Reset(rst), .IMemReq(req1), .IMemAddr(addr1), .IMemAck(ack),
        .IMemData(data1), .InstrValid(val1), .InstrReady(ready), .Instr(ins1),
        .InstrPC(ipc1), .Opcode(op1), .Redirect(redir), .RedirectPC(rpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per instance a plain ordered list of {instr, pc}
    logic        m_init;
    int          m_cnt  [2];
    logic [15:0] m_fpc  [2];
    logic        m_flush[2];
    logic [15:0] m_qi   [2][2];
    logic [15:0] m_qp   [2][2];

    initial m_init = 1'b0;

    logic        e_req, e_pop, a_req, a_val;
    logic [15:0] a_addr, a_ins, a_ipc;
    logic [2:0]  a_op;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            e_req = !rst && !m_flush[k] && (m_cnt[k] < 2) && !redir;
            if (m_init) begin
                a_req  = (k == 0) ? req0  : req1;
                a_val  = (k == 0) ? val0  : val1;
                a_addr = (k == 0) ? addr0 : addr1;
                a_ins  = (k == 0) ? ins0  : ins1;
                a_ipc  = (k == 0) ? ipc0  : ipc1;
                a_op   = (k == 0) ? op0   : op1;
                chk($sformatf("m_req%0d", k), {31'd0, a_req}, {31'd0, e_req});
                chk($sformatf("m_addr%0d", k), {16'd0, a_addr}, {16'd0, m_fpc[k]});
                chk($sformatf("m_valid%0d", k), {31'd0, a_val}, {31'd0, m_cnt[k] != 0});
                if (m_cnt[k] != 0) begin
                    chk($sformatf("m_instr%0d", k), {16'd0, a_ins}, {16'd0, m_qi[k][0]});
                    chk($sformatf("m_ipc%0d", k), {16'd0, a_ipc}, {16'd0, m_qp[k][0]});
                    chk($sformatf("m_op%0d", k), {29'd0, a_op}, {29'd0, m_qi[k][0][15:13]});
                end
            end
            if (rst) begin
                m_cnt[k]   = 0;
                m_fpc[k]   = (k == 0) ? 16'h0000 : 16'hFFFE;
                m_flush[k] = 1'b0;
            end else if (redir) begin
                m_cnt[k]   = 0;
                m_fpc[k]   = rpc;
                m_flush[k] = 1'b1;
            end else begin
                e_pop = (m_cnt[k] != 0) && ready;
                if (e_pop) begin
                    m_qi[k][0] = m_qi[k][1];
                    m_qp[k][0] = m_qp[k][1];
                    m_cnt[k]   = m_cnt[k] - 1;
                end
                if (e_req && ack) begin
                    m_qi[k][m_cnt[k]] = mem_word(m_fpc[k]);
                    m_qp[k][m_cnt[k]] = m_fpc[k];
                    m_cnt[k]          = m_cnt[k] + 1;
                    m_fpc[k]          = m_fpc[k] + 16'd1;
                end
                m_flush[k] = 1'b0;
            end
        end
        if (rst) m_init = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic peek();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; ack = 1'b1; ready = 1'b1; redir = 1'b0; rpc = 16'h0000;
        tick();
        peek();
        chk("rst_req0", {31'd0, req0}, 32'd0);
        chk("rst_valid0", {31'd0, val0}, 32'd0);
        tick();

        // Free run from reset
        rst = 1'b0;
        peek();
        chk("first_req0", {31'd0, req0}, 32'd1);
        chk("first_addr0", {16'd0, addr0}, 32'h0000);
        chk("first_addr1", {16'd0, addr1}, 32'hFFFE);
        tick();
        peek();
        chk("lat_valid0", {31'd0, val0}, 32'd1);
        chk("lat_ipc0", {16'd0, ipc0}, 32'h0000);
        chk("lat_ipc1", {16'd0, ipc1}, 32'hFFFE);
        tick();
        peek();
        chk("run_ipc0", {16'd0, ipc0}, 32'h0001);
        chk("opc_instr1", {16'd0, ins1}, 32'hE123);
        chk("opc_op1", {29'd0, op1}, 32'd7);
        chk("wrap_addr1", {16'd0, addr1}, 32'h0000);
        tick();
        peek();
        chk("wrap_ipc1", {16'd0, ipc1}, 32'h0000);
        tick();
        repeat (4) tick();

        // Reset mid-stream, then backpressure
        rst = 1'b1;
        peek();
        chk("mid_rst_req1", {31'd0, req1}, 32'd0);
        tick();
        rst = 1'b0; ready = 1'b0;
        peek();
        chk("mid_rst_valid1", {31'd0, val1}, 32'd0);
        chk("mid_rst_addr1", {16'd0, addr1}, 32'hFFFE);
        tick();
        tick();
        peek();
        chk("full_req0", {31'd0, req0}, 32'd0);
        chk("full_ipc0", {16'd0, ipc0}, 32'h0000);
        tick();
        ready = 1'b1;
        peek();
        chk("full_pop_req0", {31'd0, req0}, 32'd0);
        tick();
        ready = 1'b0;
        peek();
        chk("resume_req0", {31'd0, req0}, 32'd1);
        chk("resume_addr0", {16'd0, addr0}, 32'h0002);
        chk("resume_ipc0", {16'd0, ipc0}, 32'h0001);
        tick();

        // Slow memory: ack every third cycle
        ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            ack = (i % 3 == 2);
            tick();
        end

        // Redirect with a full queue
        ack = 1'b1; ready = 1'b0;
        repeat (3) tick();
        redir = 1'b1; rpc = 16'h0040;
        peek();
        chk("redir_req0", {31'd0, req0}, 32'd0);
        tick();
        redir = 1'b0; ready = 1'b1;
        peek();
        chk("flush_valid0", {31'd0, val0}, 32'd0);
        chk("flush_req0", {31'd0, req0}, 32'd0);
        tick();
        peek();
        chk("tgt_req0", {31'd0, req0}, 32'd1);
        chk("tgt_addr0", {16'd0, addr0}, 32'h0040);
        tick();
        peek();
        chk("tgt_valid0", {31'd0, val0}, 32'd1);
        chk("tgt_ipc0", {16'd0, ipc0}, 32'h0040);
        tick();
        peek();
        chk("pushpop_ipc0", {16'd0, ipc0}, 32'h0041);
        chk("pushpop_valid0", {31'd0, val0}, 32'd1);
        tick();

        // Pop and redirect in the same cycle
        redir = 1'b1; rpc = 16'h1234;
        tick();
        redir = 1'b0;
        peek();
        chk("poprd_valid0", {31'd0, val0}, 32'd0);
        chk("poprd_addr0", {16'd0, addr0}, 32'h1234);
        tick();
        repeat (3) tick();

        // Reset overrides a simultaneous redirect
        rst = 1'b1; redir = 1'b1; rpc = 16'h0999;
        peek();
        chk("rst_redir_req1", {31'd0, req1}, 32'd0);
        tick();
        rst = 1'b0; redir = 1'b0;
        peek();
        chk("rst_redir_valid1", {31'd0, val1}, 32'd0);
        chk("rst_redir_addr1", {16'd0, addr1}, 32'hFFFE);
        chk("rst_redir_req1b", {31'd0, req1}, 32'd1);
        chk("rst_redir_addr0", {16'd0, addr0}, 32'h0000);
        tick();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
